// File: rtl/sr_strobe_gen_pkg.sv
// Shared types and defaults for the SR-latch strobe generator.
package sr_strobe_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSetPulse = 2'd1,
        StRstPulse = 2'd2,
        StGap      = 2'd3
    } state_e;

    localparam int unsigned SyncStagesDef     = 2;
    localparam int unsigned DebounceCyclesDef = 16;
    localparam int unsigned PulseCyclesDef    = 4;
    localparam int unsigned GapCyclesDef      = 1;

    // Bits needed to hold values 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sr_strobe_gen_if.sv
// Button inputs and latch-side strobe outputs of the strobe generator.
interface sr_strobe_gen_if;
    logic btn_set;
    logic btn_reset;
    logic S_n;
    logic R_n;
    logic busy;
    logic conflict;

    modport master (
        output btn_set,
        output btn_reset,
        input  S_n,
        input  R_n,
        input  busy,
        input  conflict
    );

    modport slave (
        input  btn_set,
        input  btn_reset,
        output S_n,
        output R_n,
        output busy,
        output conflict
    );
endinterface

// File: rtl/sr_strobe_gen_debounce_sync.sv
// Synchronizer plus debouncer for one raw button; pulses req_o for one clock
// when the debounced level rises.
module debounce_sync
    import sr_strobe_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SyncStagesDef,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic req_o
);
    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q;
    logic                   level_q;
    logic                   req_q;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            req_q  <= 1'b0;
            if (sync_bit == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
                cnt_q   <= '0;
                level_q <= sync_bit;
                req_q   <= sync_bit;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/sr_strobe_gen.sv
// Turns two bouncy buttons into mutually exclusive active-low S_n/R_n strobes
// for a NAND SR latch; reset requests always win over set requests.
module sr_strobe_gen
    import sr_strobe_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SyncStagesDef,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDef,
    parameter int unsigned PULSE_CYCLES    = PulseCyclesDef,
    parameter int unsigned GAP_CYCLES      = GapCyclesDef
) (
    input  logic           clk,
    input  logic           rst,
    sr_strobe_gen_if.slave bus_io
);
    localparam int unsigned CntMax = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = cnt_width(CntMax);
    localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);

    logic set_req;
    logic rst_req;
    logic want_r;
    logic want_s;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            pend_s_q;
    logic            pend_r_q;
    logic            s_n_q;
    logic            r_n_q;
    logic            busy_q;
    logic            conflict_q;

    debounce_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_set_db (
        .clk   (clk),
        .rst   (rst),
        .btn_i (bus_io.btn_set),
        .req_o (set_req)
    );

    debounce_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_rst_db (
        .clk   (clk),
        .rst   (rst),
        .btn_i (bus_io.btn_reset),
        .req_o (rst_req)
    );

    // Pending state including this cycle's requests; a set coincident with a reset is dropped.
    assign want_r = pend_r_q | rst_req;
    assign want_s = pend_s_q | (set_req & ~rst_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pend_s_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            s_n_q      <= 1'b1;
            r_n_q      <= 1'b1;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            if (set_req && rst_req) begin
                conflict_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (rst_req) begin
                        state_q <= StRstPulse;
                        r_n_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (set_req) begin
                        state_q <= StSetPulse;
                        s_n_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StSetPulse, StRstPulse: begin
                    pend_r_q <= want_r;
                    pend_s_q <= want_s;
                    if (cnt_q == PulseLast) begin
                        state_q <= StGap;
                        cnt_q   <= '0;
                        s_n_q   <= 1'b1;
                        r_n_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        cnt_q <= '0;
                        if (want_r) begin
                            state_q  <= StRstPulse;
                            r_n_q    <= 1'b0;
                            pend_r_q <= 1'b0;
                            pend_s_q <= want_s;
                        end else if (want_s) begin
                            state_q  <= StSetPulse;
                            s_n_q    <= 1'b0;
                            pend_s_q <= 1'b0;
                            pend_r_q <= 1'b0;
                        end else begin
                            state_q  <= StIdle;
                            busy_q   <= 1'b0;
                            pend_s_q <= 1'b0;
                            pend_r_q <= 1'b0;
                        end
                    end else begin
                        cnt_q    <= cnt_q + CntW'(1);
                        pend_r_q <= want_r;
                        pend_s_q <= want_s;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    s_n_q   <= 1'b1;
                    r_n_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.S_n      = s_n_q;
    assign bus_io.R_n      = r_n_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.conflict = conflict_q;

endmodule
